// File: rtl/fft_stage_sequencer_if.sv
// ---------------------------------------------------------------------------
// fft_stage_sequencer_if
//
// Purpose: groups the command/status and butterfly bus signals of the
// radix-2 FFT stage sequencer. The control side (master) requests a
// transform. The sequencer (slave) issues butterfly read pairs and
// write-back strobes.
//
// Signals:
//   start      master->slave  single-cycle transform request
//   stall      master->slave  freeze issue (only when FFT_SEQ_STALL_EN is defined)
//   busy       slave->master  high from first issue through completion
//   done       slave->master  one-cycle completion pulse
//   stage      slave->master  current stage index
//   bf_valid   slave->master  read pair issued this cycle
//   addr_a/b   slave->master  butterfly upper/lower read addresses
//   tf_addr    slave->master  twiddle ROM address
//   bf_tag     slave->master  {addr_a, addr_b}
//   wr_en      slave->master  write-back strobe
//   wr_addr_a/b slave->master write-back addresses
//
// Macro: FFT_SEQ_STALL_EN adds the stall signal.
// ---------------------------------------------------------------------------
interface fft_stage_sequencer_if #(
  parameter int N         = 16,
  parameter int CMD_WIDTH = $clog2(N)
);
  localparam int SW = $clog2(CMD_WIDTH) + 1;

  logic                   start;
`ifdef FFT_SEQ_STALL_EN
  logic                   stall;
`endif
  logic                   busy;
  logic                   done;
  logic [SW-1:0]          stage;
  logic                   bf_valid;
  logic [CMD_WIDTH-1:0]   addr_a;
  logic [CMD_WIDTH-1:0]   addr_b;
  logic [CMD_WIDTH-1:0]   tf_addr;
  logic [2*CMD_WIDTH-1:0] bf_tag;
  logic                   wr_en;
  logic [CMD_WIDTH-1:0]   wr_addr_a;
  logic [CMD_WIDTH-1:0]   wr_addr_b;

  modport master (
    output start,
`ifdef FFT_SEQ_STALL_EN
    output stall,
`endif
    input  busy, done, stage, bf_valid, addr_a, addr_b, tf_addr, bf_tag,
    input  wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    input  start,
`ifdef FFT_SEQ_STALL_EN
    input  stall,
`endif
    output busy, done, stage, bf_valid, addr_a, addr_b, tf_addr, bf_tag,
    output wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// ---------------------------------------------------------------------------
// fft_stage_sequencer
//
// Purpose: address sequencer for an in-place radix-2 DIT FFT. It runs
// CMD_WIDTH stages of N/2 butterflies each. Every butterfly issue
// produces a read pair and a twiddle address. After each stage the
// sequencer waits PIPE_LAT idle cycles, so the butterfly pipeline's last
// write lands before the next stage reads. A PIPE_LAT-deep shift register
// re-times the read pair into write-back strobes and addresses.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   fft_stage_sequencer_if.slave (start/stall in; status,
//         read-issue and write-back signals out)
//
// All outputs come straight from flops.
//
// Macro: FFT_SEQ_STALL_EN. When defined, bus.stall freezes issue in RUN.
// When undefined, issue is never frozen.
// ---------------------------------------------------------------------------
module fft_stage_sequencer #(
  parameter int N         = 16,
  parameter int CMD_WIDTH = $clog2(N),
  parameter int PIPE_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_stage_sequencer_if.slave bus
);
  localparam int SW = $clog2(CMD_WIDTH) + 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [CMD_WIDTH-1:0] J_LAST = CMD_WIDTH'(N / 2 - 1);
  localparam logic [SW-1:0]        S_LAST = SW'(CMD_WIDTH - 1);
  localparam logic [DW-1:0]        D_LAST = DW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                 state_q;
  logic [SW-1:0]          s_q;
  logic [CMD_WIDTH-1:0]   j_q;
  logic [DW-1:0]          drain_q;

  logic                   busy_q;
  logic                   done_q;
  logic [SW-1:0]          stage_q;
  logic                   bf_valid_q;
  logic [CMD_WIDTH-1:0]   addr_a_q;
  logic [CMD_WIDTH-1:0]   addr_b_q;
  logic [CMD_WIDTH-1:0]   tf_addr_q;
  logic [2*CMD_WIDTH-1:0] bf_tag_q;

  logic [CMD_WIDTH-1:0]   half_mask_d;
  logic [CMD_WIDTH-1:0]   addr_a_d;
  logic [CMD_WIDTH-1:0]   addr_b_d;
  logic [CMD_WIDTH-1:0]   tf_addr_d;

  logic                   stall_w;

`ifdef FFT_SEQ_STALL_EN
  assign stall_w = bus.stall;
`else
  assign stall_w = 1'b0;
`endif

  // Butterfly j of stage s with half = 2^s. Shifting j right by s and back
  // left by s+1 opens a zero bit at position s. That gives the upper index.
  // The lower index sets that bit, so it is upper + half.
  always_comb begin
    half_mask_d = (CMD_WIDTH'(1) << s_q) - CMD_WIDTH'(1);
    addr_a_d    = ((j_q >> s_q) << (s_q + SW'(1))) | (j_q & half_mask_d);
    addr_b_d    = addr_a_d + (CMD_WIDTH'(1) << s_q);
    tf_addr_d   = (j_q & half_mask_d) << (S_LAST - s_q);
  end

  // Control FSM. Outputs are registered, so they appear one edge after
  // the state that produces them. The first issue lands one cycle after
  // start is sampled. The done pulse follows the DONE state by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      j_q        <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stage_q    <= '0;
      bf_valid_q <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      tf_addr_q  <= '0;
      bf_tag_q   <= '0;
    end else begin
      done_q     <= 1'b0;
      bf_valid_q <= 1'b0;
      stage_q    <= s_q;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (bus.start) begin
            state_q <= ST_RUN;
            s_q     <= '0;
            j_q     <= '0;
          end
        end
        ST_RUN: begin
          // While stalled, every index and address holds.
          if (!stall_w) begin
            bf_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            tf_addr_q  <= tf_addr_d;
            bf_tag_q   <= {addr_a_d, addr_b_d};
            if (j_q == J_LAST) begin
              j_q     <= '0;
              drain_q <= '0;
              state_q <= ST_DRAIN;
            end else begin
              j_q <= j_q + CMD_WIDTH'(1);
            end
          end
        end
        ST_DRAIN: begin
          // PIPE_LAT edges with no issue. This lets the last write-back of
          // the stage retire before the next stage's first read.
          if (drain_q == D_LAST) begin
            drain_q <= '0;
            if (s_q == S_LAST) begin
              state_q <= ST_DONE;
            end else begin
              s_q     <= s_q + SW'(1);
              state_q <= ST_RUN;
            end
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          s_q     <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Write-back re-timing. This pipeline always advances, stall included,
  // so writes already in flight still retire while issue is frozen.
  logic                 wv_q [PIPE_LAT];
  logic [CMD_WIDTH-1:0] wa_q [PIPE_LAT];
  logic [CMD_WIDTH-1:0] wb_q [PIPE_LAT];

  generate
    for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_wpipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) begin
            wv_q[gi] <= 1'b0;
            wa_q[gi] <= '0;
            wb_q[gi] <= '0;
          end else begin
            wv_q[gi] <= bf_valid_q;
            wa_q[gi] <= addr_a_q;
            wb_q[gi] <= addr_b_q;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (rst) begin
            wv_q[gi] <= 1'b0;
            wa_q[gi] <= '0;
            wb_q[gi] <= '0;
          end else begin
            wv_q[gi] <= wv_q[gi-1];
            wa_q[gi] <= wa_q[gi-1];
            wb_q[gi] <= wb_q[gi-1];
          end
        end
      end
    end
  endgenerate

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = stage_q;
  assign bus.bf_valid  = bf_valid_q;
  assign bus.addr_a    = addr_a_q;
  assign bus.addr_b    = addr_b_q;
  assign bus.tf_addr   = tf_addr_q;
  assign bus.bf_tag    = bf_tag_q;
  assign bus.wr_en     = wv_q[PIPE_LAT-1];
  assign bus.wr_addr_a = wa_q[PIPE_LAT-1];
  assign bus.wr_addr_b = wb_q[PIPE_LAT-1];
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_stage_sequencer
//
// Directed bench for fft_stage_sequencer with N=16, PIPE_LAT=2.
// Cycle c means the interval right after rising edge c. start is sampled
// at edge 0. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fft_stage_sequencer;
  localparam int N  = 16;
  localparam int CW = 4;
  localparam int PL = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_stage_sequencer_if #(.N(N), .CMD_WIDTH(CW)) bus ();

  fft_stage_sequencer #(.N(N), .CMD_WIDTH(CW), .PIPE_LAT(PL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Expected held read addresses (they hold while bf_valid is low).
  int last_a, last_b, last_tf;
  // Expected read-side history, indexed by c+2 so that entries 0/1 hold
  // the values present before start.
  bit ev [0:49];
  int ea [0:49];
  int eb [0:49];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("%s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},      32'(bus.busy),      0);
    check({tag, " done"},      32'(bus.done),      0);
    check({tag, " stage"},     32'(bus.stage),     0);
    check({tag, " bf_valid"},  32'(bus.bf_valid),  0);
    check({tag, " addr_a"},    32'(bus.addr_a),    0);
    check({tag, " addr_b"},    32'(bus.addr_b),    0);
    check({tag, " tf_addr"},   32'(bus.tf_addr),   0);
    check({tag, " bf_tag"},    32'(bus.bf_tag),    0);
    check({tag, " wr_en"},     32'(bus.wr_en),     0);
    check({tag, " wr_addr_a"}, 32'(bus.wr_addr_a), 0);
    check({tag, " wr_addr_b"}, 32'(bus.wr_addr_b), 0);
  endtask

  // Expected issue pair for stage st, butterfly j, using the textbook
  // radix-2 formula.
  task automatic expect_pair(input int st, input int j, output int a, output int b, output int tf);
    int half;
    half = 1 << st;
    a  = (j / half) * 2 * half + (j % half);
    b  = a + half;
    tf = (j % half) * (1 << (CW - 1 - st));
  endtask

  // One full transform without stall, checked cycle by cycle from c=0 to c=45.
  // With hold_start set, start stays high until after edge 41.
  task automatic run_transform(input bit hold_start, input string name);
    int wcnt [4];
    bit valid;
    int st, pos, a, b, tf;
    for (int i = 0; i < 4; i++) wcnt[i] = 0;
    ev[0] = 1'b0; ev[1] = 1'b0;
    ea[0] = last_a; ea[1] = last_a;
    eb[0] = last_b; eb[1] = last_b;
    bus.start = 1'b1;
    @(negedge clk);                           // edge 0 sampled start
    if (!hold_start) bus.start = 1'b0;
    for (int c = 0; c <= 45; c++) begin
      if (c > 0) @(negedge clk);
      valid = 1'b0;
      st = 0;
      if (c >= 1 && c <= 40) begin
        st  = (c - 1) / 10;
        pos = (c - 1) % 10;
        if (pos < 8) begin
          valid = 1'b1;
          expect_pair(st, pos, a, b, tf);
          last_a = a; last_b = b; last_tf = tf;
        end
      end
      ev[c+2] = valid;
      ea[c+2] = last_a;
      eb[c+2] = last_b;
      if (valid)
        $display("[TB] %s c=%0d stage=%0d addr_a=%0d addr_b=%0d tf=%0d", name, c,
                 bus.stage, bus.addr_a, bus.addr_b, bus.tf_addr);
      check($sformatf("%s bf_valid c=%0d", name, c), 32'(bus.bf_valid), 32'(valid));
      check($sformatf("%s busy c=%0d", name, c), 32'(bus.busy), 32'(c >= 1 && c <= 41));
      check($sformatf("%s done c=%0d", name, c), 32'(bus.done), 32'(c == 41));
      check($sformatf("%s addr_a c=%0d", name, c), 32'(bus.addr_a), last_a);
      check($sformatf("%s addr_b c=%0d", name, c), 32'(bus.addr_b), last_b);
      check($sformatf("%s tf_addr c=%0d", name, c), 32'(bus.tf_addr), last_tf);
      check($sformatf("%s bf_tag c=%0d", name, c), 32'(bus.bf_tag), (last_a << CW) | last_b);
      if (valid) check($sformatf("%s stage c=%0d", name, c), 32'(bus.stage), st);
      check($sformatf("%s wr_en c=%0d", name, c), 32'(bus.wr_en), 32'(ev[c]));
      check($sformatf("%s wr_addr_a c=%0d", name, c), 32'(bus.wr_addr_a), ea[c]);
      check($sformatf("%s wr_addr_b c=%0d", name, c), 32'(bus.wr_addr_b), eb[c]);
      if (bus.wr_en && c >= 3 && c <= 42) wcnt[(c - 3) / 10]++;
      // Hand-computed spot checks.
      if (c == 14) begin
        check({name, " s1j3 addr_a"}, 32'(bus.addr_a), 5);
        check({name, " s1j3 addr_b"}, 32'(bus.addr_b), 7);
        check({name, " s1j3 tf"},     32'(bus.tf_addr), 4);
      end
      if (c == 36) begin
        check({name, " s3j5 addr_a"}, 32'(bus.addr_a), 5);
        check({name, " s3j5 addr_b"}, 32'(bus.addr_b), 13);
        check({name, " s3j5 tf"},     32'(bus.tf_addr), 5);
      end
      if (c == 10) check({name, " last s0 write"}, 32'(bus.wr_en), 1);
      if (c == 11) check({name, " first s1 read"}, 32'(bus.bf_valid), 1);
      if (c == 41 && hold_start) bus.start = 1'b0;
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("%s wr_en count stage %0d", name, i), wcnt[i], 8);
  endtask

  initial begin
    bus.start = 1'b0;
`ifdef FFT_SEQ_STALL_EN
    bus.stall = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    last_a = 0; last_b = 0; last_tf = 0;
    @(negedge clk);

    run_transform(1'b0, "run1");
    run_transform(1'b1, "held");

    // Reset during stage 1 RUN.
    bus.start = 1'b1;
    @(negedge clk);                           // c=0
    bus.start = 1'b0;
    repeat (15) @(negedge clk);               // c=15
    check("midrst pre bf_valid", 32'(bus.bf_valid), 1);
    check("midrst pre stage",    32'(bus.stage), 1);
    rst = 1'b1;
    @(negedge clk);
    $display("[TB] reset applied at c=15");
    check_all_zero("midrst");
    rst = 1'b0;
    last_a = 0; last_b = 0; last_tf = 0;
    for (int i = 0; i < PL + 1; i++) begin
      @(negedge clk);
      check($sformatf("postrst wr_en %0d", i),    32'(bus.wr_en), 0);
      check($sformatf("postrst bf_valid %0d", i), 32'(bus.bf_valid), 0);
      check($sformatf("postrst busy %0d", i),     32'(bus.busy), 0);
    end

`ifdef FFT_SEQ_STALL_EN
    begin
      int k, done_c, stall_valids, a, b, tf;
      k = 0; done_c = -1; stall_valids = 0;
      bus.start = 1'b1;
      @(negedge clk);                         // c=0
      bus.start = 1'b0;
      for (int c = 1; c <= 60 && done_c < 0; c++) begin
        @(negedge clk);
        if (bus.bf_valid) begin
          expect_pair(k / 8, k % 8, a, b, tf);
          $display("[TB] stall c=%0d addr_a=%0d addr_b=%0d", c, bus.addr_a, bus.addr_b);
          check($sformatf("stall seq a k=%0d", k), 32'(bus.addr_a), a);
          check($sformatf("stall seq b k=%0d", k), 32'(bus.addr_b), b);
          k++;
        end
        if (c >= 23 && c <= 25 && bus.bf_valid) stall_valids++;
        if (bus.done) done_c = c;
        bus.stall = (c >= 22 && c <= 24);
      end
      bus.stall = 1'b0;
      check("stall issue count", k, 32);
      check("stall frozen cycles", stall_valids, 0);
      check("stall done cycle", done_c, 44);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 SHALL have parameter N, default 16, FFT length; power of two, at least 4.
REQ-002 SHALL have parameter CMD_WIDTH, default $clog2(N), width of index, address and twiddle address.
REQ-003 SHALL have parameter PIPE_LAT, default 2, butterfly read-to-write latency in cycles; at least 1.
REQ-004 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- start  in  1  single-cycle request to run one transform.
- stall  in  1  freezes issue; present only per REQ-021.
- busy  out  1  high from first issue cycle through the DONE cycle.
- done  out  1  one-cycle pulse at completion.
- stage  out  $clog2(CMD_WIDTH)+1  current stage s.
- bf_valid  out  1  read pair issued this cycle.
- addr_a  out  CMD_WIDTH  butterfly upper read address.
- addr_b  out  CMD_WIDTH  butterfly lower read address.
- tf_addr  out  CMD_WIDTH  twiddlefactors ROM address.
- bf_tag  out  2*CMD_WIDTH  {addr_a,addr_b}, drives butterfly m_in.
- wr_en  out  1  write-back strobe.
- wr_addr_a  out  CMD_WIDTH  write address for out_a.
- wr_addr_b  out  CMD_WIDTH  write address for out_b.

Function
REQ-005 SHALL register all outputs; none SHALL be driven combinationally from inputs.
REQ-006 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-007 IDLE: start=1 -> RUN with s=0, j=0; otherwise hold.
REQ-008 RUN: each non-stalled cycle SHALL assert bf_valid and issue butterfly j, j = 0..N/2-1; after j=N/2-1 -> DRAIN.
REQ-009 Issue addressing, radix-2 in-place DIT with half=2^s:
- addr_a = (j>>s)*2*half + (j & (half-1))
- addr_b = addr_a + half
- tf_addr = (j & (half-1)) << (CMD_WIDTH-1-s)
REQ-010 DRAIN SHALL last exactly PIPE_LAT cycles with bf_valid=0. At its end: s<CMD_WIDTH-1 -> RUN with s+1, j=0; otherwise -> DONE.
REQ-011 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-012 wr_en, wr_addr_a and wr_addr_b SHALL equal bf_valid, addr_a and addr_b delayed by exactly PIPE_LAT cycles through a shift register.
- The shift register is never frozen by stall.
REQ-013 The last write of a stage SHALL occur no later than the cycle before the first read of the next stage.
REQ-014 Total latency: N=16, PIPE_LAT=2, no stall:
- start sampled at edge 0.
- First bf_valid at cycle 1.
- done at cycle 41.
- Generally, done comes 1 + CMD_WIDTH*(N/2+PIPE_LAT) cycles after start.
REQ-015 start SHALL be ignored when the state is not IDLE.
REQ-016 All index arithmetic SHALL be unsigned and CMD_WIDTH bits wide; j SHALL wrap to 0 at each stage change.
REQ-017 When bf_valid=0, addr_a, addr_b, tf_addr and bf_tag SHALL hold their last values.

Reset
REQ-018 rst=1 at a clock edge SHALL force state IDLE, s=0, j=0, and clear the write shift register.
REQ-019 After reset, every output SHALL be 0.
REQ-020 rst SHALL take priority over start and stall at every point, including mid-RUN and mid-DRAIN.
- No wr_en SHALL follow reset for issues made before the reset.

Configuration
REQ-021 Macro FFT_SEQ_STALL_EN, when defined, SHALL include the stall port.
- stall=1 in RUN: bf_valid=0; j, s and addresses held; state unchanged.
- stall has no effect in IDLE, DRAIN or DONE.
- Undefined: the stall port is absent and issue is never frozen.

Verification
REQ-022 rst, then start pulse, N=16, PIPE_LAT=2 -> stage 0 issues (0,1),(2,3)..(14,15) with tf_addr=0; done at cycle 41; busy high for cycles 1-41.
REQ-023 Stage 1, j=3 -> addr_a=5, addr_b=7, tf_addr=4; stage 3, j=5 -> addr_a=5, addr_b=13, tf_addr=5.
REQ-024 Per stage -> wr_en high for exactly 8 cycles; each wr_addr pair equals the issue pair from 2 cycles earlier; last stage-0 write at cycle 10, first stage-1 read at cycle 11.
REQ-025 start held high throughout a transform -> exactly one run; a new run begins only when start is sampled in IDLE after DONE.
REQ-026 rst asserted at cycle 15 (stage 1 RUN) -> all outputs 0 from the next edge; no wr_en for the following PIPE_LAT cycles.
REQ-027 With FFT_SEQ_STALL_EN, stall=1 for 3 cycles during stage 2 -> bf_valid low for 3 cycles; same address sequence; done delayed to cycle 44.
